// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writebacks win, queued MDU results drain in the free slots.
// A pipeline write squashes older queued writes to the same register (WAW).
module wb_write_arbiter #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_we,
    input  logic [4:0]               pipe_rd,
    input  logic [31:0]              pipe_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_rd,
    input  logic [31:0]              mdu_data,
    input  logic [4:0]               query_rs,
    input  logic [4:0]               query_rt,
    output logic                     busy_rs,
    output logic                     busy_rt,
    output logic                     RegWrite,
    output logic [4:0]               Write_register,
    output logic [31:0]              Write_data,
    output logic [$clog2(DEPTH):0]   pending_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             regwrite_q, regwrite_d;
    logic [4:0]       wr_reg_q, wr_reg_d;
    logic [31:0]      wr_data_q, wr_data_d;

    logic pipe_wr;
    logic enq;
    logic pop;

    assign mdu_ready = (count_q < CW'(DEPTH));
    assign pipe_wr   = pipe_we && (pipe_rd != 5'd0);
    assign enq       = mdu_valid && mdu_ready && (mdu_rd != 5'd0);
    assign pop       = !pipe_wr && (count_q != '0);

    // Next-state: squash first, then pop, then enqueue so a same-cycle entry stays live.
    always_comb begin
        live_d     = live_q;
        rd_d       = rd_q;
        data_d     = data_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        regwrite_d = 1'b0;
        wr_reg_d   = wr_reg_q;
        wr_data_d  = wr_data_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (pipe_wr && (rd_q[PW'(i)] == pipe_rd)) begin
                live_d[PW'(i)] = 1'b0;
            end
        end

        if (pipe_wr) begin
            regwrite_d = 1'b1;
            wr_reg_d   = pipe_rd;
            wr_data_d  = pipe_data;
        end else if (pop) begin
            regwrite_d = live_q[rptr_q];
            if (live_q[rptr_q]) begin
                wr_reg_d  = rd_q[rptr_q];
                wr_data_d = data_q[rptr_q];
            end
            live_d[rptr_q] = 1'b0;
            rptr_d         = rptr_q + PW'(1);
        end

        if (enq) begin
            live_d[wptr_q] = 1'b1;
            rd_d[wptr_q]   = mdu_rd;
            data_d[wptr_q] = mdu_data;
            wptr_d         = wptr_q + PW'(1);
        end

        if (enq && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!enq && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            regwrite_q <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rd_q[PW'(i)]   <= '0;
                data_q[PW'(i)] <= '0;
            end
        end else begin
            live_q     <= live_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            regwrite_q <= regwrite_d;
            wr_reg_q   <= wr_reg_d;
            wr_data_q  <= wr_data_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
        end
    end

    // Scoreboard lookup over live queued entries only; r0 is never busy.
    always_comb begin
        busy_rs = 1'b0;
        busy_rt = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (live_q[PW'(i)] && (query_rs != 5'd0) && (rd_q[PW'(i)] == query_rs)) begin
                busy_rs = 1'b1;
            end
            if (live_q[PW'(i)] && (query_rt != 5'd0) && (rd_q[PW'(i)] == query_rt)) begin
                busy_rt = 1'b1;
            end
        end
    end

    assign RegWrite       = regwrite_q;
    assign Write_register = wr_reg_q;
    assign Write_data     = wr_data_q;
    assign pending_count  = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_write_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        busy_rs;
    logic        busy_rt;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic [2:0]  pending_count;

    int total = 0;
    int bad   = 0;

    wb_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .query_rs(query_rs), .query_rt(query_rt), .busy_rs(busy_rs), .busy_rt(busy_rt),
        .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of pending writes plus the register-file port value.
    typedef struct {
        logic        live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic        m_accepted;

    function automatic logic m_busy(input logic [4:0] q);
        m_busy = 1'b0;
        if (q != 5'd0) begin
            foreach (mq[i]) if (mq[i].live && mq[i].rd == q) m_busy = 1'b1;
        end
    endfunction

    function automatic logic m_ready();
        m_ready = (mq.size() < DEPTH);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_rw = 1'b0;
        m_wr = 5'd0;
        m_wd = 32'd0;
        m_accepted = 1'b0;
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_step();
        ent_t h;
        bit   pw;
        bit   rdy;
        pw  = pipe_we && (pipe_rd != 5'd0);
        rdy = m_ready();
        m_accepted = mdu_valid && rdy;
        if (pw) begin
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].live = 1'b0;
            m_rw = 1'b1;
            m_wr = pipe_rd;
            m_wd = pipe_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_rw = h.live;
            if (h.live) begin
                m_wr = h.rd;
                m_wd = h.data;
            end
        end else begin
            m_rw = 1'b0;
        end
        if (m_accepted && mdu_rd != 5'd0) begin
            h.live = 1'b1;
            h.rd   = mdu_rd;
            h.data = mdu_data;
            mq.push_back(h);
        end
    endtask

    task automatic set_in(input logic pwe, input logic [4:0] prd, input logic [31:0] pd,
                          input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        query_rs = 5'd0; query_rt = 5'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        total++; if (Write_register !== 5'd0) begin bad++; $display("FAIL reset_wr got=%0d exp=0", Write_register); end
        total++; if (Write_data !== 32'd0) begin bad++; $display("FAIL reset_wd got=%h exp=0", Write_data); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pending_count); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", mdu_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_enqueue();
        query_rs = 5'd5;
        set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hAAAA5555);
        tick();
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        total++; if (pending_count !== 3'd1) begin bad++; $display("FAIL single_count1 got=%0d exp=1", pending_count); end
        total++; if (busy_rs !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy_rs); end
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL single_rw_early got=%b exp=0", RegWrite); end
        tick();
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd5, 32'hAAAA5555}) begin
            bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/aaaa5555", RegWrite, Write_register, Write_data);
        end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL single_count0 got=%0d exp=0", pending_count); end
        tick();
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL single_rw_idle got=%b exp=0", RegWrite); end
    endtask

    task automatic test_fill_backpressure();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 5'(k + 1), 32'h100 + 32'(k), 1'b1, 5'(10 + k), 32'hB0 + 32'(k));
            tick();
            total++; if ({RegWrite, Write_register} !== {1'b1, 5'(k + 1)}) begin
                bad++; $display("FAIL fill_pipe k=%0d got=%b/%0d exp=1/%0d", k, RegWrite, Write_register, k + 1);
            end
        end
        total++; if (pending_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d exp=4", pending_count); end
        total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL fill_ready got=%b exp=0", mdu_ready); end
        set_in(1'b1, 5'd5, 32'h105, 1'b1, 5'd14, 32'hB4);
        tick();
        total++; if (pending_count !== 3'd4) begin bad++; $display("FAIL fill_held got=%0d exp=4", pending_count); end
        set_in(1'b1, 5'd0, 32'd0, 1'b1, 5'd14, 32'hB4);
        tick();
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd10, 32'hB0}) begin
            bad++; $display("FAIL fill_pop got=%b/%0d/%h exp=1/10/b0", RegWrite, Write_register, Write_data);
        end
        total++; if (pending_count !== 3'd3) begin bad++; $display("FAIL fill_after_pop got=%0d exp=3", pending_count); end
        tick();
        total++; if (pending_count !== 3'd3) begin bad++; $display("FAIL fill_accept5 got=%0d exp=3", pending_count); end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (3) tick();
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd14, 32'hB4}) begin
            bad++; $display("FAIL fill_last got=%b/%0d/%h exp=1/14/b4", RegWrite, Write_register, Write_data);
        end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL fill_drained got=%0d exp=0", pending_count); end
    endtask

    task automatic test_waw_squash();
        int stale = 0;
        query_rs = 5'd7;
        set_in(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h1);
        tick();
        total++; if (busy_rs !== 1'b1) begin bad++; $display("FAIL squash_busy1 got=%b exp=1", busy_rs); end
        set_in(1'b1, 5'd7, 32'h2, 1'b0, 5'd0, 32'd0);
        tick();
        if (RegWrite && Write_register == 5'd7 && Write_data != 32'h2) stale++;
        total++; if (busy_rs !== 1'b0) begin bad++; $display("FAIL squash_busy0 got=%b exp=0", busy_rs); end
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd7, 32'h2}) begin
            bad++; $display("FAIL squash_pipe got=%b/%0d/%h exp=1/7/2", RegWrite, Write_register, Write_data);
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        if (RegWrite && Write_register == 5'd7 && Write_data != 32'h2) stale++;
        total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL squash_pop_rw got=%b exp=0", RegWrite); end
        total++; if (pending_count !== 3'd0) begin bad++; $display("FAIL squash_count got=%0d exp=0", pending_count); end
        tick();
        if (RegWrite && Write_register == 5'd7 && Write_data != 32'h2) stale++;
        total++; if (stale !== 0) begin bad++; $display("FAIL squash_stale got=%0d exp=0", stale); end
    endtask

    task automatic test_same_cycle_rd();
        query_rt = 5'd9;
        set_in(1'b1, 5'd9, 32'hBBBB, 1'b1, 5'd9, 32'hAAAA);
        tick();
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd9, 32'hBBBB}) begin
            bad++; $display("FAIL same_pipe got=%b/%0d/%h exp=1/9/bbbb", RegWrite, Write_register, Write_data);
        end
        total++; if (busy_rt !== 1'b1) begin bad++; $display("FAIL same_busy got=%b exp=1", busy_rt); end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if ({RegWrite, Write_register, Write_data} !== {1'b1, 5'd9, 32'hAAAA}) begin
            bad++; $display("FAIL same_mdu got=%b/%0d/%h exp=1/9/aaaa", RegWrite, Write_register, Write_data);
        end
        tick();
        total++; if ({RegWrite, Write_data} !== {1'b0, 32'hAAAA}) begin
            bad++; $display("FAIL same_persist got=%b/%h exp=0/aaaa", RegWrite, Write_data);
        end
    endtask

    task automatic test_zero_rd();
        set_in(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
        tick();
        total++; if ({RegWrite, pending_count} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL zero_rd1 got=%b/%0d exp=0/0", RegWrite, pending_count);
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if ({RegWrite, pending_count} !== {1'b0, 3'd0}) begin
            bad++; $display("FAIL zero_rd2 got=%b/%0d exp=0/0", RegWrite, pending_count);
        end
    endtask

    task automatic test_reset_mid();
        query_rs = 5'd20;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b1, 5'd1, 32'h0, 1'b1, 5'(20 + k), 32'hC0 + 32'(k));
            tick();
        end
        total++; if ({pending_count, busy_rs} !== {3'd3, 1'b1}) begin
            bad++; $display("FAIL mid_prefill got=%0d/%b exp=3/1", pending_count, busy_rs);
        end
        set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 reset = 1'b1;
        model_clear();
        #1;
        total++; if ({RegWrite, pending_count, busy_rs} !== {1'b0, 3'd0, 1'b0}) begin
            bad++; $display("FAIL mid_reset got=%b/%0d/%b exp=0/0/0", RegWrite, pending_count, busy_rs);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL mid_stale k=%0d got=%b exp=0", k, RegWrite); end
        end
    endtask

    task automatic test_random();
        logic        hold_v = 1'b0;
        logic [4:0]  hold_rd = 5'd0;
        logic [31:0] hold_d = 32'd0;
        for (int c = 0; c < 400; c++) begin
            if (!hold_v || m_accepted) begin
                hold_v  = ($urandom_range(0, 9) < 6);
                hold_rd = 5'($urandom_range(0, 7));
                hold_d  = $urandom;
            end
            set_in(($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom, hold_v, hold_rd, hold_d);
            query_rs = 5'($urandom_range(0, 7));
            query_rt = 5'($urandom_range(0, 7));
            #1;
            total++; if (mdu_ready !== m_ready()) begin bad++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, mdu_ready, m_ready()); end
            total++; if ({busy_rs, busy_rt} !== {m_busy(query_rs), m_busy(query_rt)}) begin
                bad++; $display("FAIL rand_busy c=%0d got=%b%b exp=%b%b", c, busy_rs, busy_rt, m_busy(query_rs), m_busy(query_rt));
            end
            tick();
            m_accepted = m_accepted && hold_v;
            total++; if ({RegWrite, Write_register, Write_data} !== {m_rw, m_wr, m_wd}) begin
                bad++; $display("FAIL rand_port c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, RegWrite, Write_register, Write_data, m_rw, m_wr, m_wd);
            end
            total++; if (pending_count !== 3'(mq.size())) begin
                bad++; $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, pending_count, mq.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_enqueue();
        test_fill_backpressure();
        test_waw_squash();
        test_same_cycle_rd();
        test_zero_rd();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
